// File: rtl/reset_ctrl.sv
// Global reset sequencer: merges POR, software and external-pin resets, stretches and
// handshakes with every domain's synchronized reset. Define RESET_DEBOUNCE_EN to debounce ext_reset_n.
module reset_ctrl #(
  parameter int NUM_DOMAINS       = 2,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int ACK_TIMEOUT       = 1024,
  parameter int DEBOUNCE_CYCLES   = 1000
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   sw_reset_req,
  input  logic                   ext_reset_n,
  input  logic [NUM_DOMAINS-1:0] dom_reset,
  output logic                   reset_out,
  output logic                   reset_busy,
  output logic [1:0]             reset_cause,
  output logic                   timeout_err
);

  localparam int CNT_MAX_A = (MIN_ASSERT_CYCLES > ACK_TIMEOUT) ? MIN_ASSERT_CYCLES : ACK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > DEBOUNCE_CYCLES) ? CNT_MAX_A : DEBOUNCE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MIN_TC = CW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] ACK_TC = CW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_ASSERT      = 2'd1;
  localparam logic [1:0] ST_WAIT_ASSERT = 2'd2;
  localparam logic [1:0] ST_RELEASE     = 2'd3;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  logic [1:0]             ext_sync_q, ext_sync_d;
  logic [NUM_DOMAINS-1:0] dom_meta_q, dom_meta_d;
  logic [NUM_DOMAINS-1:0] dom_s_q, dom_s_d;
  logic                   ext_rst_s;
  logic                   ext_act;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rout_q, rout_d;
  logic          busy_q, busy_d;
  logic [1:0]    cause_q, cause_d;
  logic          terr_q, terr_d;

  // Synchronizers come out of reset in the asserted state.
  always_comb begin
    ext_sync_d = {ext_sync_q[0], ~ext_reset_n};
    dom_meta_d = dom_reset;
    dom_s_d    = dom_meta_q;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ext_sync_q <= 2'b11;
      dom_meta_q <= '1;
      dom_s_q    <= '1;
    end else begin
      ext_sync_q <= ext_sync_d;
      dom_meta_q <= dom_meta_d;
      dom_s_q    <= dom_s_d;
    end
  end

  assign ext_rst_s = ext_sync_q[1];

`ifdef RESET_DEBOUNCE_EN
  localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] deb_cnt_q, deb_cnt_d;

  // Saturating run-length of high samples; any low sample restarts it.
  always_comb begin
    deb_cnt_d = '0;
    if (ext_rst_s) begin
      deb_cnt_d = (deb_cnt_q == DEB_TC) ? deb_cnt_q : deb_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign ext_act = (deb_cnt_q == DEB_TC);
`else
  assign ext_act = ext_rst_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rout_d  = rout_q;
    cause_d = cause_q;
    terr_d  = terr_q;
    case (state_q)
      ST_RUN: begin
        rout_d = 1'b0;
        if (ext_act) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rout_d  = 1'b1;
          cause_d = CAUSE_EXT;
        end else if (sw_reset_req) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rout_d  = 1'b1;
          cause_d = CAUSE_SW;
        end
      end
      ST_ASSERT: begin
        rout_d = 1'b1;
        if (cnt_q == MIN_TC) begin
          if (!ext_act) begin
            state_d = ST_WAIT_ASSERT;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_ASSERT: begin
        rout_d = 1'b1;
        if (ext_act) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          cause_d = CAUSE_EXT;
        end else if (&dom_s_q) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          rout_d  = 1'b0;
        end else if (cnt_q == ACK_TC) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          rout_d  = 1'b0;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        rout_d = 1'b0;
        if (ext_act) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rout_d  = 1'b1;
          cause_d = CAUSE_EXT;
        end else if (~|dom_s_q) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == ACK_TC) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        rout_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      rout_q  <= 1'b1;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rout_q  <= rout_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
      terr_q  <= terr_d;
    end
  end

  assign reset_out   = rout_q;
  assign reset_busy  = busy_q;
  assign reset_cause = cause_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl: domains are modelled as delayed echoes of reset_out,
// expected reset/busy window lengths are computed from the sequencing rules.
`timescale 1ns/1ps
module tb_reset_ctrl;

  localparam int ND         = 2;
  localparam int MIN_ASSERT = 16;
  localparam int ACK_TO     = 32;
  localparam int DEB        = 8;

  logic          clk          = 1'b0;
  logic          areset       = 1'b0;
  logic          sw_reset_req = 1'b0;
  logic          ext_reset_n  = 1'b1;
  logic [ND-1:0] dom_reset;
  logic          reset_out;
  logic          reset_busy;
  logic [1:0]    reset_cause;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  int            dly [ND] = '{default: 3};
  logic [ND-1:0] stuck_lo = '0;
  logic [ND-1:0] stuck_hi = '0;
  logic [63:0]   hist     = '0;

  reset_ctrl #(
    .NUM_DOMAINS      (ND),
    .MIN_ASSERT_CYCLES(MIN_ASSERT),
    .ACK_TIMEOUT      (ACK_TO),
    .DEBOUNCE_CYCLES  (DEB)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .sw_reset_req(sw_reset_req),
    .ext_reset_n (ext_reset_n),
    .dom_reset   (dom_reset),
    .reset_out   (reset_out),
    .reset_busy  (reset_busy),
    .reset_cause (reset_cause),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Each domain echoes reset_out after its own delay; stuck bits override it.
  always @(posedge clk) hist <= {hist[62:0], reset_out};

  always_comb begin
    dom_reset = '0;
    for (int i = 0; i < ND; i++) begin
      dom_reset[i] = stuck_hi[i] | (~stuck_lo[i] & hist[dly[i]-1]);
    end
  end

  // reset_out high samples: the hold lasts max(assert length, slowest ack + 2 sync stages),
  // plus one cycle to act on the ack.
  function automatic int exp_rout_high(int assert_len, int dmax);
    int w;
    w = (assert_len > dmax + 2) ? assert_len : dmax + 2;
    return w + 1;
  endfunction

  // Busy extends past reset_out by the slowest domain release plus 2 sync stages and one decision.
  function automatic int exp_busy_high(int rout_high, int dmax);
    return rout_high + dmax + 3;
  endfunction

  task automatic pick_delays(output int dmax);
    dmax = 0;
    for (int i = 0; i < ND; i++) begin
      dly[i] = int'($urandom_range(8, 1));
      if (dly[i] > dmax) dmax = dly[i];
    end
  endtask

  task automatic measure(output int rh, output int bh, output bit done);
    rh = 0;
    bh = 0;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (reset_busy !== 1'b1) begin
        done = 1'b1;
        break;
      end
      bh++;
      if (reset_out === 1'b1) rh++;
      @(negedge clk);
    end
  endtask

  task automatic idle();
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_sw();
    @(negedge clk);
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
  endtask

  task automatic test_reset();
    int dmax, rh, bh, erh, ebh;
    bit done;
    pick_delays(dmax);
    @(negedge clk);
    areset = 1'b1;
    #1;
    checks++; if (reset_out !== 1'b1) begin errors++; $display("FAIL por_rout: got %b expected 1", reset_out); end
    checks++; if (reset_busy !== 1'b1) begin errors++; $display("FAIL por_busy: got %b expected 1", reset_busy); end
    checks++; if (reset_cause !== 2'b00) begin errors++; $display("FAIL por_cause: got %b expected 00", reset_cause); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL por_terr: got %b expected 0", timeout_err); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    measure(rh, bh, done);
    erh = MIN_ASSERT;
    ebh = exp_busy_high(erh, dmax);
    checks++; if (!done) begin errors++; $display("FAIL por_done: busy still high after 400 cycles"); end
    checks++; if (rh != erh) begin errors++; $display("FAIL por_rout_len: got %0d expected %0d", rh, erh); end
    checks++; if (bh != ebh) begin errors++; $display("FAIL por_busy_len: got %0d expected %0d", bh, ebh); end
    checks++; if (reset_cause !== 2'b00) begin errors++; $display("FAIL por_cause_end: got %b expected 00", reset_cause); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL por_terr_end: got %b expected 0", timeout_err); end
    $display("por: dmax=%0d rout_high=%0d busy_high=%0d", dmax, rh, bh);
    idle();
  endtask

  task automatic test_sw_reset(input bit exp_terr);
    int dmax, rh, bh, erh;
    bit done;
    pick_delays(dmax);
    @(negedge clk);
    checks++; if (reset_busy !== 1'b0 || reset_out !== 1'b0) begin errors++; $display("FAIL sw_idle: got busy=%b rout=%b expected 0/0", reset_busy, reset_out); end
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    checks++; if (reset_out !== 1'b1) begin errors++; $display("FAIL sw_latency: got %b expected 1", reset_out); end
    measure(rh, bh, done);
    erh = exp_rout_high(MIN_ASSERT, dmax);
    checks++; if (!done) begin errors++; $display("FAIL sw_done: busy still high after 400 cycles"); end
    checks++; if (rh != erh) begin errors++; $display("FAIL sw_rout_len: got %0d expected %0d", rh, erh); end
    checks++; if (bh != exp_busy_high(erh, dmax)) begin errors++; $display("FAIL sw_busy_len: got %0d expected %0d", bh, exp_busy_high(erh, dmax)); end
    checks++; if (reset_cause !== 2'b10) begin errors++; $display("FAIL sw_cause: got %b expected 10", reset_cause); end
    checks++; if (timeout_err !== exp_terr) begin errors++; $display("FAIL sw_terr: got %b expected %b", timeout_err, exp_terr); end
    $display("sw: dmax=%0d rout_high=%0d busy_high=%0d", dmax, rh, bh);
    idle();
  endtask

  task automatic test_ext_priority();
    int dmax, rh, bh, len, erh;
    bit done;
    pick_delays(dmax);
    len = int'($urandom_range(50, 20));
    @(negedge clk);
    ext_reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // SW request lands on the same edge as the first synchronized EXT sample.
    sw_reset_req = 1'b1;
    checks++; if (reset_out !== 1'b0) begin errors++; $display("FAIL ext_early: got %b expected 0", reset_out); end
    @(negedge clk);
    sw_reset_req = 1'b0;
    checks++; if (reset_out !== 1'b1) begin errors++; $display("FAIL ext_latency: got %b expected 1", reset_out); end
    fork
      begin
        repeat (len - 3) @(negedge clk);
        ext_reset_n = 1'b1;
      end
      measure(rh, bh, done);
    join
    erh = exp_rout_high((len > MIN_ASSERT) ? len : MIN_ASSERT, dmax);
    checks++; if (!done) begin errors++; $display("FAIL ext_done: busy still high after 400 cycles"); end
    checks++; if (rh != erh) begin errors++; $display("FAIL ext_rout_len: got %0d expected %0d", rh, erh); end
    checks++; if (bh != exp_busy_high(erh, dmax)) begin errors++; $display("FAIL ext_busy_len: got %0d expected %0d", bh, exp_busy_high(erh, dmax)); end
    checks++; if (reset_cause !== 2'b01) begin errors++; $display("FAIL ext_cause: got %b expected 01", reset_cause); end
    $display("ext: hold=%0d dmax=%0d rout_high=%0d busy_high=%0d", len, dmax, rh, bh);
    idle();
  endtask

  task automatic test_retrigger();
    int dmax, rh, bh, erh, k;
    bit done;
    pick_delays(dmax);
    stuck_hi[0] = 1'b1;
    pulse_sw();
    k = 0;
    while (reset_out !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k >= 100) begin errors++; $display("FAIL retrig_release: reset_out never fell"); end
    // Now in RELEASE, held there by the stuck-high domain.
    ext_reset_n = 1'b0;
    stuck_hi[0] = 1'b0;
    @(negedge clk);
    checks++; if (reset_out !== 1'b0) begin errors++; $display("FAIL retrig_gap1: got %b expected 0", reset_out); end
    @(negedge clk);
    checks++; if (reset_out !== 1'b0) begin errors++; $display("FAIL retrig_gap2: got %b expected 0", reset_out); end
    @(negedge clk);
    ext_reset_n = 1'b1;
    checks++; if (reset_out !== 1'b1) begin errors++; $display("FAIL retrig_reassert: got %b expected 1", reset_out); end
    measure(rh, bh, done);
    erh = exp_rout_high(MIN_ASSERT, dmax);
    checks++; if (!done) begin errors++; $display("FAIL retrig_done: busy still high after 400 cycles"); end
    checks++; if (rh != erh) begin errors++; $display("FAIL retrig_rout_len: got %0d expected %0d", rh, erh); end
    checks++; if (bh != exp_busy_high(erh, dmax)) begin errors++; $display("FAIL retrig_busy_len: got %0d expected %0d", bh, exp_busy_high(erh, dmax)); end
    checks++; if (reset_cause !== 2'b01) begin errors++; $display("FAIL retrig_cause: got %b expected 01", reset_cause); end
    $display("retrigger: dmax=%0d rout_high=%0d busy_high=%0d", dmax, rh, bh);
    idle();
  endtask

  task automatic test_release_timeout();
    int dmax, rh, bh, erh;
    bit done;
    pick_delays(dmax);
    stuck_hi[0] = 1'b1;
    pulse_sw();
    measure(rh, bh, done);
    erh = exp_rout_high(MIN_ASSERT, dly[1]);
    checks++; if (!done) begin errors++; $display("FAIL reltmo_done: busy still high after 400 cycles"); end
    checks++; if (rh != erh) begin errors++; $display("FAIL reltmo_rout_len: got %0d expected %0d", rh, erh); end
    checks++; if (bh != erh + ACK_TO) begin errors++; $display("FAIL reltmo_busy_len: got %0d expected %0d", bh, erh + ACK_TO); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL reltmo_terr: got %b expected 1", timeout_err); end
    $display("release_timeout: rout_high=%0d busy_high=%0d terr=%b", rh, bh, timeout_err);
    stuck_hi[0] = 1'b0;
    idle();
  endtask

  task automatic test_wait_timeout();
    int dmax, rh, bh;
    bit done;
    pick_delays(dmax);
    stuck_lo[1] = 1'b1;
    pulse_sw();
    measure(rh, bh, done);
    checks++; if (!done) begin errors++; $display("FAIL waittmo_done: busy still high after 400 cycles"); end
    checks++; if (rh != MIN_ASSERT + ACK_TO) begin errors++; $display("FAIL waittmo_rout_len: got %0d expected %0d", rh, MIN_ASSERT + ACK_TO); end
    checks++; if (bh != exp_busy_high(MIN_ASSERT + ACK_TO, dly[0])) begin errors++; $display("FAIL waittmo_busy_len: got %0d expected %0d", bh, exp_busy_high(MIN_ASSERT + ACK_TO, dly[0])); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL waittmo_terr: got %b expected 1", timeout_err); end
    $display("wait_timeout: rout_high=%0d busy_high=%0d terr=%b", rh, bh, timeout_err);
    stuck_lo[1] = 1'b0;
    idle();
    test_sw_reset(1'b1);
  endtask

`ifdef RESET_DEBOUNCE_EN
  task automatic test_debounce();
    int dmax, rh, bh, early, erh;
    bit done;
    pick_delays(dmax);
    @(negedge clk);
    ext_reset_n = 1'b0;
    repeat (DEB - 3) @(negedge clk);
    ext_reset_n = 1'b1;
    early = 0;
    repeat (DEB + 8) begin
      @(negedge clk);
      if (reset_busy !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL deb_glitch: got %0d busy cycles expected 0", early); end
    ext_reset_n = 1'b0;
    early = 0;
    for (int k = 1; k <= DEB + 2; k++) begin
      @(negedge clk);
      if (k == DEB) ext_reset_n = 1'b1;
      if (reset_out !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL deb_early: got %0d high cycles expected 0", early); end
    @(negedge clk);
    checks++; if (reset_out !== 1'b1) begin errors++; $display("FAIL deb_latency: got %b expected 1", reset_out); end
    measure(rh, bh, done);
    erh = exp_rout_high(MIN_ASSERT, dmax);
    checks++; if (!done) begin errors++; $display("FAIL deb_done: busy still high after 400 cycles"); end
    checks++; if (rh != erh) begin errors++; $display("FAIL deb_rout_len: got %0d expected %0d", rh, erh); end
    checks++; if (reset_cause !== 2'b01) begin errors++; $display("FAIL deb_cause: got %b expected 01", reset_cause); end
    $display("debounce: dmax=%0d rout_high=%0d busy_high=%0d", dmax, rh, bh);
    idle();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    for (int n = 0; n < 3; n++) test_sw_reset(1'b0);
`ifndef RESET_DEBOUNCE_EN
    test_ext_priority();
    test_ext_priority();
    test_retrigger();
`endif
    test_release_timeout();
    test_reset();
    test_wait_timeout();
`ifdef RESET_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
